// File: rtl/uart_pkg.sv
// Shared frame constants, FSM state types and baud-divisor helper for the UART endpoint.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;

    // PARITY states are only entered when the parity option is compiled in.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period down-counter; restart realigns it to the current edge.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick_full,
    output logic tick_half
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLKS_PER_BIT - 1);
    // Fires CLKS_PER_BIT/2 cycles after a restart.
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= LOAD;
        end else if (restart || count == '0) begin
            count <= LOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick_full = (count == '0);
    assign tick_half = (count == HALF);

endmodule

// File: rtl/uart_driver.sv
// Full-duplex 8N1 UART endpoint bridging serial lines to RX/TX byte streams.
// Optional parity bit after bit 7 when UART_PARITY_EN is defined (PARITY_ODD selects odd).
module uart_driver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_uart_rx_serial,
    input  logic                 io_uart_rx_data_ready,
    output logic                 io_uart_rx_data_valid,
    output logic [DATA_BITS-1:0] io_uart_rx_data_bits_tdata,
    output logic                 io_uart_tx_serial,
    output logic                 io_uart_tx_data_ready,
    input  logic                 io_uart_tx_data_valid,
    input  logic [DATA_BITS-1:0] io_uart_tx_data_bits_tdata
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BIT_CNT_W-1:0] tx_bit_cnt;
    logic                 tx_handshake;
    logic                 tx_tick;
    logic                 tx_tick_half_unused;

    rx_state_t            rx_state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [DATA_BITS-1:0] rx_shift;
    logic [BIT_CNT_W-1:0] rx_bit_cnt;
    logic                 rx_wait_high;
    logic                 rx_tick;
    logic                 rx_tick_half;
    logic                 rx_restart;
    logic                 rx_par_good;
    logic                 rx_deliver;

`ifdef UART_PARITY_EN
    logic tx_parity;
    logic rx_par_ok;
    assign rx_par_good = rx_par_ok;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign rx_par_good = 1'b1;
`endif

    // ready is high only in TX_IDLE, so a handshake always starts a frame.
    assign tx_handshake = io_uart_tx_data_valid && io_uart_tx_data_ready;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (tx_handshake),
        .tick_full(tx_tick),
        .tick_half(tx_tick_half_unused)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state              <= TX_IDLE;
            tx_shift              <= '0;
            tx_bit_cnt            <= '0;
            io_uart_tx_serial     <= STOP_BIT;
            io_uart_tx_data_ready <= 1'b1;
`ifdef UART_PARITY_EN
            tx_parity             <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_handshake) begin
                        tx_shift              <= io_uart_tx_data_bits_tdata;
`ifdef UART_PARITY_EN
                        tx_parity             <= (^io_uart_tx_data_bits_tdata) ^ PARITY_ODD;
`endif
                        tx_state              <= TX_START;
                        io_uart_tx_serial     <= START_BIT;
                        io_uart_tx_data_ready <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_state          <= TX_DATA;
                        tx_bit_cnt        <= '0;
                        io_uart_tx_serial <= tx_shift[0];
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_state          <= TX_PARITY;
                            io_uart_tx_serial <= tx_parity;
`else
                            tx_state          <= TX_STOP;
                            io_uart_tx_serial <= STOP_BIT;
`endif
                        end else begin
                            tx_bit_cnt        <= tx_bit_cnt + 1'b1;
                            tx_shift          <= tx_shift >> 1;
                            io_uart_tx_serial <= tx_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        tx_state          <= TX_STOP;
                        io_uart_tx_serial <= STOP_BIT;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_state              <= TX_IDLE;
                        io_uart_tx_data_ready <= 1'b1;
                    end
                end
                default: begin
                    tx_state              <= TX_IDLE;
                    io_uart_tx_serial     <= STOP_BIT;
                    io_uart_tx_data_ready <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= io_uart_rx_serial;
            rx_sync <= rx_meta;
        end
    end

    // Realign at the falling edge and again at mid-start, so data ticks land mid-bit.
    assign rx_restart = ((rx_state == RX_IDLE) || (rx_state == RX_START && rx_tick_half))
                        && (rx_sync == START_BIT);
    assign rx_deliver = (rx_state == RX_STOP) && !rx_wait_high && rx_tick
                        && (rx_sync == STOP_BIT) && rx_par_good;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (rx_restart),
        .tick_full(rx_tick),
        .tick_half(rx_tick_half)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state     <= RX_IDLE;
            rx_shift     <= '0;
            rx_bit_cnt   <= '0;
            rx_wait_high <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok    <= 1'b1;
`endif
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_sync == START_BIT) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_tick_half) begin
                        if (rx_sync == START_BIT) begin
                            rx_state   <= RX_DATA;
                            rx_bit_cnt <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
`ifdef UART_PARITY_EN
                        rx_par_ok <= (rx_sync == ((^rx_shift) ^ PARITY_ODD));
`endif
                        rx_state  <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // A low stop bit means framing error: hold off until the line idles.
                    if (rx_wait_high) begin
                        if (rx_sync == STOP_BIT) begin
                            rx_wait_high <= 1'b0;
                            rx_state     <= RX_IDLE;
                        end
                    end else if (rx_tick) begin
                        if (rx_sync == STOP_BIT) rx_state <= RX_IDLE;
                        else rx_wait_high <= 1'b1;
                    end
                end
                default: begin
                    rx_state     <= RX_IDLE;
                    rx_wait_high <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry holding register; a byte arriving while full is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_uart_rx_data_valid      <= 1'b0;
            io_uart_rx_data_bits_tdata <= '0;
        end else if (rx_deliver && (!io_uart_rx_data_valid || io_uart_rx_data_ready)) begin
            io_uart_rx_data_valid      <= 1'b1;
            io_uart_rx_data_bits_tdata <= rx_shift;
        end else if (io_uart_rx_data_valid && io_uart_rx_data_ready) begin
            io_uart_rx_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_driver.sv
// Directed bench for uart_driver at 10 clocks per bit: TX frames, RX delivery, overrun, errors, reset.
module tb_uart_driver;

    localparam int CLOCK_FREQ = 1000000;
    localparam int BAUD_RATE  = 100000;
    localparam int CPB        = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_serial;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_tdata;
    logic       tx_serial;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_tdata;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_driver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .io_uart_rx_serial         (rx_serial),
        .io_uart_rx_data_ready     (rx_ready),
        .io_uart_rx_data_valid     (rx_valid),
        .io_uart_rx_data_bits_tdata(rx_tdata),
        .io_uart_tx_serial         (tx_serial),
        .io_uart_tx_data_ready     (tx_ready),
        .io_uart_tx_data_valid     (tx_valid),
        .io_uart_tx_data_bits_tdata(tx_tdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit period, index 0 first on the wire
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
    } rx_vec_t;

    // RX output monitor
    int         rx_events = 0;
    int         rx_high   = 0;
    logic       rx_valid_q = 1'b0;
    logic [7:0] rx_first_data = 8'h00;
    time        rx_first_t = 0;
    time        rx_start_t = 0;

    always @(negedge clock) begin
        if (rx_valid) rx_high++;
        if (rx_valid && !rx_valid_q) begin
            rx_events++;
            rx_first_t    = $time;
            rx_first_data = rx_tdata;
        end
        rx_valid_q = rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tx_frame(input logic [7:0] b, input logic [9:0] exp);
        int bad;
        int rdy_bad;
        int waited;
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check($sformatf("tx %02h ready before send", b), tx_ready, 32'd1);
        tx_valid = 1'b1;
        tx_tdata = b;
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
        rdy_bad = 0;
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                if (tx_serial !== exp[k]) bad++;
                if (tx_ready !== 1'b0) rdy_bad++;
            end
            check($sformatf("tx %02h bit%0d wrong-level clocks", b, k), bad, 32'd0);
        end
        check($sformatf("tx %02h ready high during frame", b), rdy_bad, 32'd0);
        @(negedge clock);
        check($sformatf("tx %02h ready after frame", b), tx_ready, 32'd1);
        check($sformatf("tx %02h line idle after frame", b), tx_serial, 32'd1);
    endtask

    // Called on a negedge; returns on a negedge with the line idle.
    task automatic rx_drive(input logic [7:0] b, input logic stop);
        rx_start_t = $time;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx_serial = stop;
        repeat (CPB) @(negedge clock);
        rx_serial = 1'b1;
    endtask

    task automatic rx_case(input logic [7:0] b, input logic stop, input logic exp_valid,
                           input logic [7:0] exp_data);
        int  ev0;
        int  hi0;
        time lat;
        ev0 = rx_events;
        hi0 = rx_high;
        @(negedge clock);
        rx_drive(b, stop);
        repeat (20) @(negedge clock);
        check($sformatf("rx %02h stop%0b deliveries", b, stop), rx_events - ev0, {31'd0, exp_valid});
        if (exp_valid) begin
            check($sformatf("rx %02h data", b), rx_first_data, exp_data);
            check($sformatf("rx %02h valid cycles", b), rx_high - hi0, 32'd1);
            lat = (rx_first_t - rx_start_t) / CPB;
            check($sformatf("rx %02h latency %0d in 94..100", b, lat),
                  (lat >= 94 && lat <= 100), 32'd1);
        end
    endtask

    initial begin
        #50000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_vec_t tx_vecs[4];
        rx_vec_t rx_vecs[5];
        int      ev0;

        tx_vecs[0] = '{8'h55, 10'b1010101010};
        tx_vecs[1] = '{8'h0F, 10'b1000011110};
        tx_vecs[2] = '{8'h00, 10'b1000000000};
        tx_vecs[3] = '{8'hA3, 10'b1101000110};

        rx_vecs[0] = '{8'hA3, 1'b1, 1'b1, 8'hA3};
        rx_vecs[1] = '{8'h7E, 1'b0, 1'b0, 8'h00};
        rx_vecs[2] = '{8'h42, 1'b1, 1'b1, 8'h42};
        rx_vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00};
        rx_vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF};

        reset     = 1'b1;
        rx_serial = 1'b1;
        rx_ready  = 1'b1;
        tx_valid  = 1'b0;
        tx_tdata  = 8'h00;
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset tx_serial", tx_serial, 32'd1);
        check("reset tx_ready", tx_ready, 32'd1);
        check("reset rx_valid", rx_valid, 32'd0);
        check("reset rx_tdata", rx_tdata, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 4; i++) tx_frame(tx_vecs[i].data, tx_vecs[i].frame);

        for (int i = 0; i < 5; i++)
            rx_case(rx_vecs[i].data, rx_vecs[i].stop, rx_vecs[i].exp_valid, rx_vecs[i].exp_data);

        // Overrun: second byte arrives while the first is still held.
        rx_ready = 1'b0;
        ev0 = rx_events;
        @(negedge clock);
        rx_drive(8'h11, 1'b1);
        repeat (5) @(negedge clock);
        rx_drive(8'h22, 1'b1);
        repeat (20) @(negedge clock);
        check("overrun valid held", rx_valid, 32'd1);
        check("overrun first byte kept", rx_tdata, 32'h11);
        check("overrun single delivery", rx_events - ev0, 32'd1);
        rx_ready = 1'b1;
        @(negedge clock);
        check("overrun valid cleared", rx_valid, 32'd0);
        repeat (20) @(negedge clock);
        check("overrun second byte dropped", rx_events - ev0, 32'd1);

        // Short low glitch must not start a frame.
        ev0 = rx_events;
        @(negedge clock);
        rx_serial = 1'b0;
        repeat (3) @(negedge clock);
        rx_serial = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch no delivery", rx_events - ev0, 32'd0);
        rx_case(8'h3C, 1'b1, 1'b1, 8'h3C);

        // Reset in the middle of a TX frame.
        @(negedge clock);
        tx_valid = 1'b1;
        tx_tdata = 8'hAA;
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
        repeat (35) @(negedge clock);
        check("mid-frame line low before reset", tx_serial, 32'd0);
        check("mid-frame ready low before reset", tx_ready, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async reset tx_serial", tx_serial, 32'd1);
        check("async reset tx_ready", tx_ready, 32'd1);
        check("async reset rx_valid", rx_valid, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tx_frame(8'hFF, 10'b1111111110);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_driver.md
Name: uart_driver

Overview:
- Full-duplex 8N1 UART endpoint. Converts between the serial lines and two byte-wide ready/valid streams, one for RX and one for TX.
- Sits between a pin-level UART and an on-chip byte producer/consumer. Typical uses: host bridges and simulation transactors.
- RX and TX are independent and run concurrently.

Parameters:
- CLOCK_FREQ, 100000000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer divide), required >= 4.

Ports:
- clock  in  1  single system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- io_uart_rx_serial  in  1  serial input, asynchronous to clock, idle high.
- io_uart_rx_data_ready  in  1  consumer accepts the RX byte.
- io_uart_rx_data_valid  out  1  RX byte available.
- io_uart_rx_data_bits_tdata  out  8  received byte.
- io_uart_tx_serial  out  1  serial output, idle high.
- io_uart_tx_data_ready  out  1  TX accepts a byte.
- io_uart_tx_data_valid  in  1  producer offers a byte.
- io_uart_tx_data_bits_tdata  in  8  byte to transmit.

Behaviour:
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
- Reset values: tx_serial=1, tx_data_ready=1, rx_data_valid=0, rx_data_bits_tdata=0. Both FSMs go to IDLE and all counters clear. Reset mid-frame aborts immediately and the line returns high; no partial byte is ever delivered.
- TX FSM states: IDLE, START, DATA, STOP.
  - tx_data_ready=1 only in IDLE.
  - A handshake (valid&&ready) latches tdata. On the next edge the FSM enters START and drives tx_serial=0; ready drops the same cycle.
  - DATA shifts bits 0..7. STOP drives 1 for CLKS_PER_BIT clocks, then returns to IDLE, where ready=1 again.
  - Frame length is exactly 10*CLKS_PER_BIT clocks. Back-to-back bytes produce no extra idle bit beyond 1 clock of IDLE.
  - tx_serial is registered and glitch-free.
- RX input: rx_serial passes through a 2-flop synchronizer, initialised to 1 on reset.
- RX FSM states: IDLE, START, DATA, STOP.
  - In IDLE, a synchronized 0 starts a frame. The line is re-sampled at CLKS_PER_BIT/2; if it reads 1, the event is a glitch and the FSM returns to IDLE.
  - Data bits are sampled every CLKS_PER_BIT from the mid-start point, LSB first.
  - Stop bit sampled at its midpoint. If 0, it is a framing error: the byte is discarded and the FSM waits for the line to read 1 before returning to IDLE. If 1, the byte is delivered and the FSM returns to IDLE immediately, at mid-stop.
- RX output register: one entry.
  - Delivery sets rx_data_valid=1 with tdata the cycle after the stop-bit sample.
  - valid stays high and tdata stays stable until valid&&ready, which clears valid on the next edge.
  - Overrun: a new byte that completes while valid is still held is dropped; the old byte is kept.
  - If delivery and a handshake occur in the same cycle, the new byte is loaded and valid stays 1.
- No flow control on the line. RX never stalls the serial input.

Optional Feature:
- UART_PARITY_EN: when defined, a parity bit is inserted after bit 7 (frame = 11 bits). Parameter PARITY_ODD (default 0 = even) selects the parity.
  - TX generates the parity bit.
  - RX checks it; a mismatch discards the byte, handled the same as a framing error.
- Without the macro: plain 8N1, and PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - frame constants: DATA_BITS=8, START_BIT=0, STOP_BIT=1;
  - the typedef'd FSM state enums for TX and RX;
  - a function computing CLKS_PER_BIT.
- One natural sub-module, uart_bit_timer: a parameterised down-counter producing bit-period and half-period ticks. It is instantiated once in TX and once in RX.

Test Plan (CLOCK_FREQ=1000000, BAUD_RATE=100000, CLKS_PER_BIT=10):
- TX byte 0x55 on valid with ready=1 -> tx_serial: 0 for 10 clks, then 1,0,1,0,1,0,1,0 for 10 clks each, then 1 for 10 clks. ready low for 100 clks.
- Serial 0xA3 driven into rx with ready=1 -> rx valid pulses for 1 cycle with tdata=0xA3, ~96 clks after the start edge.
- RX 0x11 then 0x22 with ready=0 -> valid stays 1 with tdata=0x11; 0x22 is dropped. After ready=1, valid clears.
- RX frame 0x7E with stop bit forced 0 -> no valid asserted. A following good 0x42 is received correctly.
- 3-clock low glitch on rx -> no valid; FSM back in IDLE.
- reset=0 asserted mid-TX frame -> tx_serial=1 and ready=1 immediately (asynchronously). After release, a new byte 0xFF transmits correctly.
